pulse_seq_gen: RTL and testbench
================================

Name: pulse_seq_gen

Overview:
- Transmit-side companion to the two-ONE/two-ZERO sequence detector.
- Serialises a programmed symbol pattern onto the ONE and ZERO pulse lines.
- Each symbol is a clean pulse of fixed width followed by a low gap, so the detector's rising-edge logic sees exactly one event per symbol.
- Used as the stimulus source driving the detector and as the reusable front end for any ONE/ZERO pulse-line consumer.

Parameters:
- MAX_LEN, 8: maximum number of symbols per sequence; pattern width.
- PULSE_W, 2: cycles each ONE/ZERO pulse is held high; must be >= 1.
- GAP_W, 1: cycles both lines are held low after every pulse; must be >= 1.
- CW, $clog2(MAX_LEN+1): width of the length and count fields.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to send a sequence; sampled only in IDLE.
- pattern  input  MAX_LEN  symbol bits; bit i is symbol i, sent LSB first; 1 = ONE pulse, 0 = ZERO pulse.
- len  input  CW  number of symbols to send; values above MAX_LEN are clamped to MAX_LEN.
- ONE  output  1  registered ONE pulse line.
- ZERO  output  1  registered ZERO pulse line.
- busy  output  1  high while a sequence is in progress.
- done  output  1  single-cycle completion strobe.
- sent_ones  output  CW  ONE pulses issued in the current/last sequence.
- sent_zeros  output  CW  ZERO pulses issued in the current/last sequence.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: all outputs and state registers clear immediately on reset assertion, independent of clk: ONE=0, ZERO=0, busy=0, done=0, sent_ones=0, sent_zeros=0, state=IDLE.
- Reset mid-sequence: the sequence aborts; no done strobe is issued.
- All outputs are registered; ONE and ZERO are never both high and never glitch.
- FSM states: IDLE, PULSE, GAP, FIN.
- IDLE:
  - start=1 at edge k: latch pattern, latch min(len, MAX_LEN), idx=0, clear both counters.
  - If latched len=0: go to FIN.
  - Otherwise go to PULSE: busy=1 from edge k+1.
- PULSE (entered at edge k+1):
  - Drive ONE=pattern[idx] and ZERO=~pattern[idx] for exactly PULSE_W cycles.
  - On entry, increment sent_ones or sent_zeros by one, so the count updates together with the pulse's rising edge.
- GAP:
  - ONE=ZERO=0 for exactly GAP_W cycles.
  - At the end of the gap, if idx == len-1 go to FIN; else increment idx and go to PULSE.
- FIN:
  - Lasts one cycle: done=1, busy=0, ONE=ZERO=0; then go to IDLE.
  - Counters hold their values until the next accepted start.
- Timing: symbol i rises at edge k+1+i*(PULSE_W+GAP_W); done is high for the single cycle following edge k+1+len*(PULSE_W+GAP_W).
- len=0: done is high for the cycle after edge k+1, no pulses are emitted, and both counters read 0.
- start while busy, or in FIN, is ignored; it is not queued.
- pattern and len may change freely after acceptance without affecting the sequence in flight.
- Counters never wrap: the maximum value is MAX_LEN, which fits in CW bits.

Test Plan:
- Reset, then start with pattern=8'b0000_0101, len=4 (defaults) -> ONE high at edges 1-2 and 7-8, ZERO high at edges 4-5 and 10-11, both low at gaps; done=1 for the single cycle after edge 13; sent_ones=2, sent_zeros=2. Feeding ONE/ZERO into the detector drives its out to 1.
- Start with len=0 -> done=1 for the single cycle after edge 1, ONE=ZERO=0 throughout, counters=0.
- Start with len=12, pattern=8'hFF -> len clamped to 8: 8 ONE pulses, sent_ones=8, done at edge 25.
- Pulse start again at edge 5 of a running sequence, and again in the FIN cycle -> both ignored; exactly one done strobe; counters unaffected.
- Assert reset asynchronously mid-PULSE, between clock edges -> ONE/ZERO/busy drop to 0 before the next edge, no done strobe; a later start runs a fresh sequence from symbol 0.
- Reconfigure PULSE_W=1, GAP_W=3, pattern=8'b10, len=2 -> ZERO high at edge 1 only, ONE high at edge 5 only; done in the cycle after edge 9.

Source files
------------

// File: rtl/pulse_seq_gen.sv
// Serialises a latched symbol pattern onto ONE/ZERO pulse lines, one clean
// pulse plus a low gap per symbol, with a single-cycle done strobe at the end.
module pulse_seq_gen #(
    parameter int MAX_LEN = 8,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1,
    parameter int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [CW-1:0]      len,
    output logic               ONE,
    output logic               ZERO,
    output logic               busy,
    output logic               done,
    output logic [CW-1:0]      sent_ones,
    output logic [CW-1:0]      sent_zeros
);

    localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] P_LAST  = TW'(PULSE_W - 1);
    localparam logic [TW-1:0] G_LAST  = TW'(GAP_W - 1);
    localparam logic [CW-1:0] LEN_MAX = CW'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        FIN
    } state_t;

    state_t             state_reg, state_next;
    logic               launch_reg, launch_next;
    logic [MAX_LEN-1:0] pat_reg, pat_next;
    logic [CW-1:0]      len_reg, len_next;
    logic [CW-1:0]      idx_reg, idx_next;
    logic [TW-1:0]      tmr_reg, tmr_next;
    logic               one_next, zero_next, busy_next, done_next;
    logic [CW-1:0]      ones_next, zeros_next;
    logic               enter_pulse;

    // Symbol selected for the pulse about to start: index 0 on launch,
    // otherwise the symbol following the current one.
    logic [CW-1:0]      idx_sel;
    logic [MAX_LEN-1:0] sym_hit;
    logic               sym;

    assign idx_sel = (state_reg == IDLE) ? '0 : idx_reg + CW'(1);

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_sym
            assign sym_hit[gi] = pat_reg[gi] & (idx_sel == CW'(gi));
        end
    endgenerate

    assign sym = |sym_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            launch_reg <= 1'b0;
            pat_reg    <= '0;
            len_reg    <= '0;
            idx_reg    <= '0;
            tmr_reg    <= '0;
            ONE        <= 1'b0;
            ZERO       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_ones  <= '0;
            sent_zeros <= '0;
        end else begin
            state_reg  <= state_next;
            launch_reg <= launch_next;
            pat_reg    <= pat_next;
            len_reg    <= len_next;
            idx_reg    <= idx_next;
            tmr_reg    <= tmr_next;
            ONE        <= one_next;
            ZERO       <= zero_next;
            busy       <= busy_next;
            done       <= done_next;
            sent_ones  <= ones_next;
            sent_zeros <= zeros_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        launch_next = 1'b0;
        pat_next    = pat_reg;
        len_next    = len_reg;
        idx_next    = idx_reg;
        tmr_next    = tmr_reg;
        one_next    = 1'b0;
        zero_next   = 1'b0;
        ones_next   = sent_ones;
        zeros_next  = sent_zeros;
        enter_pulse = 1'b0;

        case (state_reg)
            IDLE: begin
                // Acceptance takes one edge; the first pulse rises on the next.
                if (launch_reg) begin
                    if (len_reg == '0) begin
                        state_next = FIN;
                    end else begin
                        enter_pulse = 1'b1;
                    end
                end else if (start) begin
                    launch_next = 1'b1;
                    pat_next    = pattern;
                    len_next    = (len > LEN_MAX) ? LEN_MAX : len;
                    idx_next    = '0;
                    ones_next   = '0;
                    zeros_next  = '0;
                end
            end
            PULSE: begin
                if (tmr_reg == P_LAST) begin
                    state_next = GAP;
                    tmr_next   = '0;
                end else begin
                    tmr_next  = tmr_reg + TW'(1);
                    one_next  = ONE;
                    zero_next = ZERO;
                end
            end
            GAP: begin
                if (tmr_reg == G_LAST) begin
                    tmr_next = '0;
                    if (idx_reg + CW'(1) == len_reg) begin
                        state_next = FIN;
                    end else begin
                        enter_pulse = 1'b1;
                    end
                end else begin
                    tmr_next = tmr_reg + TW'(1);
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The symbol counter moves on the same edge the pulse rises.
        if (enter_pulse) begin
            state_next = PULSE;
            tmr_next   = '0;
            idx_next   = idx_sel;
            one_next   = sym;
            zero_next  = ~sym;
            if (sym) begin
                ones_next = sent_ones + CW'(1);
            end else begin
                zeros_next = sent_zeros + CW'(1);
            end
        end

        busy_next = (state_next == PULSE) || (state_next == GAP);
        done_next = (state_next == FIN);
    end

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Bench for pulse_seq_gen: table vectors, hand sequences and random runs,
// each cycle compared against a timeline model built from symbol arithmetic.
module tb_pulse_seq_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;

    logic       ONE1, ZERO1, busy1, done1;
    logic [3:0] ones1, zeros1;
    logic       ONE2, ZERO2, busy2, done2;
    logic [3:0] ones2, zeros2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pulse_seq_gen #(.MAX_LEN(8), .PULSE_W(2), .GAP_W(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .pattern(pattern), .len(len),
        .ONE(ONE1), .ZERO(ZERO1), .busy(busy1), .done(done1),
        .sent_ones(ones1), .sent_zeros(zeros1)
    );

    pulse_seq_gen #(.MAX_LEN(8), .PULSE_W(1), .GAP_W(3)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .pattern(pattern), .len(len),
        .ONE(ONE2), .ZERO(ZERO2), .busy(busy2), .done(done2),
        .sent_ones(ones2), .sent_zeros(zeros2)
    );

    typedef struct {
        int one;
        int zero;
        int busy;
        int done;
        int ones;
        int zeros;
    } obs_t;

    typedef struct {
        bit         sel;
        logic [7:0] pat;
        int         ln;
        int         poke_edge;
        bit         poke_fin;
        int         exp_ones;
        int         exp_zeros;
        int         exp_done_t;
    } vec_t;

    // Expected outputs t edges after the accepting edge, from the symbol timeline.
    function automatic obs_t model(input int t, input logic [7:0] pat, input int len_in,
                                   input int pw, input int gw);
        obs_t e;
        int l, per, last, i, ph, c;
        e.one = 0; e.zero = 0; e.busy = 0; e.done = 0; e.ones = 0; e.zeros = 0;
        l    = (len_in > 8) ? 8 : len_in;
        per  = pw + gw;
        last = l * per;
        if (t == 0) return e;
        if (t <= last) begin
            i  = (t - 1) / per;
            ph = (t - 1) % per;
            c  = 0;
            for (int j = 0; j <= i; j++) c += int'(pat[j]);
            e.busy  = 1;
            e.one   = (ph < pw && pat[i] == 1'b1) ? 1 : 0;
            e.zero  = (ph < pw && pat[i] == 1'b0) ? 1 : 0;
            e.ones  = c;
            e.zeros = i + 1 - c;
        end else begin
            c = 0;
            for (int j = 0; j < l; j++) c += int'(pat[j]);
            e.ones  = c;
            e.zeros = l - c;
            e.done  = (t == last + 1) ? 1 : 0;
        end
        return e;
    endfunction

    function automatic obs_t sample(input bit sel);
        obs_t a;
        if (sel) begin
            a.one = int'(ONE2); a.zero = int'(ZERO2); a.busy = int'(busy2);
            a.done = int'(done2); a.ones = int'(ones2); a.zeros = int'(zeros2);
        end else begin
            a.one = int'(ONE1); a.zero = int'(ZERO1); a.busy = int'(busy1);
            a.done = int'(done1); a.ones = int'(ones1); a.zeros = int'(zeros1);
        end
        return a;
    endfunction

    task automatic chk(input string name, input int t, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s t=%0d got=%0d expected=%0d", name, t, act, exp);
        end
    endtask

    task automatic chk_obs(input string tag, input int t, input obs_t a, input obs_t e);
        chk({tag, ".ONE"}, t, a.one, e.one);
        chk({tag, ".ZERO"}, t, a.zero, e.zero);
        chk({tag, ".busy"}, t, a.busy, e.busy);
        chk({tag, ".done"}, t, a.done, e.done);
        chk({tag, ".sent_ones"}, t, a.ones, e.ones);
        chk({tag, ".sent_zeros"}, t, a.zeros, e.zeros);
    endtask

    task automatic scramble();
        start1  = 1'b0;
        start2  = 1'b0;
        pattern = 8'($urandom);
        len     = 4'($urandom);
    endtask

    // One sequence: issue start, then compare every cycle until well after done.
    task automatic run(input bit sel, input logic [7:0] pat, input int ln,
                       input int poke_edge, input bit poke_fin,
                       output int done_t, output int n_done,
                       output int f_ones, output int f_zeros);
        int   lc, per, last;
        obs_t a, e;
        lc     = (ln > 8) ? 8 : ln;
        per    = sel ? 4 : 3;
        last   = lc * per;
        done_t = -1;
        n_done = 0;
        a      = sample(sel);
        @(negedge clk);
        pattern = pat;
        len     = 4'(ln);
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1 scramble();
        for (int t = 0; t <= last + 4; t++) begin
            if (t > 0) begin
                if (t == poke_edge || (poke_fin && t == last + 2)) begin
                    if (sel) start2 = 1'b1; else start1 = 1'b1;
                end
                @(posedge clk);
                #1 scramble();
            end
            @(negedge clk);
            a = sample(sel);
            e = model(t, pat, ln, sel ? 1 : 2, sel ? 3 : 1);
            chk_obs(sel ? "dut2" : "dut1", t, a, e);
            if (a.done != 0) begin
                n_done++;
                if (done_t < 0) done_t = t;
            end
        end
        f_ones  = a.ones;
        f_zeros = a.zeros;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        int   dt, nd, fo, fz;
        obs_t a, zero_obs;
        bit   sel;
        int   ln, lc, pk;
        logic [7:0] pat;

        zero_obs.one = 0; zero_obs.zero = 0; zero_obs.busy = 0;
        zero_obs.done = 0; zero_obs.ones = 0; zero_obs.zeros = 0;

        vecs[0]  = '{1'b0, 8'h05, 4,  -1, 1'b0, 2, 2, 13};
        vecs[1]  = '{1'b0, 8'hFF, 0,  -1, 1'b0, 0, 0, 1};
        vecs[2]  = '{1'b0, 8'hFF, 12, -1, 1'b0, 8, 0, 25};
        vecs[3]  = '{1'b0, 8'hA5, 8,  -1, 1'b0, 4, 4, 25};
        vecs[4]  = '{1'b0, 8'h0E, 3,  -1, 1'b0, 2, 1, 10};
        vecs[5]  = '{1'b0, 8'hF0, 5,  -1, 1'b0, 1, 4, 16};
        vecs[6]  = '{1'b0, 8'h05, 4,  5,  1'b1, 2, 2, 13};
        vecs[7]  = '{1'b1, 8'h02, 2,  -1, 1'b0, 1, 1, 9};
        vecs[8]  = '{1'b1, 8'h00, 0,  -1, 1'b0, 0, 0, 1};
        vecs[9]  = '{1'b1, 8'h3C, 9,  -1, 1'b0, 4, 4, 33};
        vecs[10] = '{1'b0, 8'h80, 1,  -1, 1'b0, 0, 1, 4};

        // Reset state
        #12;
        chk_obs("rst1", 0, sample(1'b0), zero_obs);
        chk_obs("rst2", 0, sample(1'b1), zero_obs);
        reset = 1'b0;

        foreach (vecs[v]) begin
            run(vecs[v].sel, vecs[v].pat, vecs[v].ln, vecs[v].poke_edge, vecs[v].poke_fin,
                dt, nd, fo, fz);
            chk($sformatf("vec%0d.done_edge", v), dt, dt, vecs[v].exp_done_t);
            chk($sformatf("vec%0d.done_count", v), dt, nd, 1);
            chk($sformatf("vec%0d.final_ones", v), dt, fo, vecs[v].exp_ones);
            chk($sformatf("vec%0d.final_zeros", v), dt, fz, vecs[v].exp_zeros);
            $display("[TB] vec %0d sel=%0d pat=%h len=%0d done_t=%0d ones=%0d zeros=%0d",
                     v, vecs[v].sel, vecs[v].pat, vecs[v].ln, dt, fo, fz);
        end

        // Asynchronous reset in the middle of the first pulse
        @(negedge clk);
        pattern = 8'h05;
        len     = 4'd4;
        start1  = 1'b1;
        @(posedge clk);
        #1 scramble();
        @(posedge clk);
        #2;
        chk("pre_rst.ONE", 1, int'(ONE1), 1);
        reset = 1'b1;
        #1;
        chk("async_rst.ONE", 1, int'(ONE1), 0);
        chk("async_rst.ZERO", 1, int'(ZERO1), 0);
        chk("async_rst.busy", 1, int'(busy1), 0);
        chk("async_rst.sent_ones", 1, int'(ones1), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done1) nd++;
            chk("post_rst.busy", c, int'(busy1), 0);
            chk("post_rst.ONE", c, int'(ONE1), 0);
        end
        chk("post_rst.done_count", 0, nd, 0);
        $display("[TB] async reset mid-pulse: done strobes after abort=%0d", nd);
        run(1'b0, 8'h05, 4, -1, 1'b0, dt, nd, fo, fz);
        chk("fresh.done_edge", dt, dt, 13);
        chk("fresh.final_ones", dt, fo, 2);
        $display("[TB] fresh run after reset done_t=%0d ones=%0d zeros=%0d", dt, fo, fz);

        // Randomised sequences, ignored start pulses included
        for (int r = 0; r < 25; r++) begin
            sel = 1'($urandom_range(0, 1));
            pat = 8'($urandom);
            ln  = $urandom_range(0, 15);
            lc  = (ln > 8) ? 8 : ln;
            pk  = (lc > 0) ? $urandom_range(2, lc * (sel ? 4 : 3) + 1) : -1;
            run(sel, pat, ln, pk, 1'($urandom_range(0, 1)), dt, nd, fo, fz);
            chk($sformatf("rand%0d.done_count", r), dt, nd, 1);
            $display("[TB] rand %0d sel=%0d pat=%h len=%0d poke=%0d done_t=%0d ones=%0d zeros=%0d",
                     r, sel, pat, ln, pk, dt, fo, fz);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
